// File: rtl/pic_pkg.sv
// Shared definitions for the CPU-side interrupt acknowledge sequencer:
// FSM state encoding, vector width and default acknowledge timing.
package pic_pkg;

    localparam int unsigned VEC_W = 8;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_INTA_LOW_CYCLES = 2;
    localparam int unsigned DEF_INTA_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        PULSE1,
        GAP,
        PULSE2,
        HOLD
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage single-bit synchroniser for asynchronous PIC-facing inputs.
// Output is the input delayed through STAGES flops; reset clears the chain.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser chain register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// 8086-style interrupt acknowledge sequencer. Synchronises the PIC INT line,
// issues two INTA_n pulses, captures the vector byte on the second pulse and
// hands it to the CPU core through a valid/ack handshake.
// Optional build macro SPURIOUS_DETECT_EN adds the spurious output, flagging
// a request whose INT had dropped by the end of the inter-pulse gap.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned INTA_LOW_CYCLES = DEF_INTA_LOW_CYCLES,
    parameter int unsigned INTA_GAP_CYCLES = DEF_INTA_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             int_in,
    input  logic             intr_en,
    input  logic [VEC_W-1:0] d_in,
    output logic             inta_n,
    output logic             busy,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    input  logic             vector_ack
`ifdef SPURIOUS_DETECT_EN
    ,
    output logic             spurious
`endif
);

    localparam int unsigned CNT_MAX = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                                      INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);

    logic int_s;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             inta_n_q, inta_n_d;
    logic             busy_q,   busy_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic             valid_q,  valid_d;
`ifdef SPURIOUS_DETECT_EN
    logic             spur_flag_q, spur_flag_d;
    logic             spurious_q,  spurious_d;
`endif

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (int_in),
        .q     (int_s)
    );

    // Next-state and next-output logic; outputs change on the edge that
    // enters each state so INTA_n is glitch-free straight from a flop
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inta_n_d = inta_n_q;
        busy_d   = busy_q;
        vector_d = vector_q;
        valid_d  = valid_q;
`ifdef SPURIOUS_DETECT_EN
        spur_flag_d = spur_flag_q;
        spurious_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (int_s && intr_en) begin
                    state_d  = PULSE1;
                    cnt_d    = LOW_LOAD;
                    inta_n_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            PULSE1: begin
                if (cnt_q == '0) begin
                    state_d  = GAP;
                    cnt_d    = GAP_LOAD;
                    inta_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d  = PULSE2;
                    cnt_d    = LOW_LOAD;
                    inta_n_d = 1'b0;
`ifdef SPURIOUS_DETECT_EN
                    // Second pulse is still issued; the PIC answers with IR7
                    spur_flag_d = ~int_s;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE2: begin
                if (cnt_q == '0) begin
                    state_d  = HOLD;
                    inta_n_d = 1'b1;
                    vector_d = d_in;
                    valid_d  = 1'b1;
`ifdef SPURIOUS_DETECT_EN
                    spurious_d = spur_flag_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (vector_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                inta_n_d = 1'b1;
                busy_d   = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs; reset releases INTA_n at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            inta_n_q <= 1'b1;
            busy_q   <= 1'b0;
            vector_q <= '0;
            valid_q  <= 1'b0;
`ifdef SPURIOUS_DETECT_EN
            spur_flag_q <= 1'b0;
            spurious_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_n_q <= inta_n_d;
            busy_q   <= busy_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
`ifdef SPURIOUS_DETECT_EN
            spur_flag_q <= spur_flag_d;
            spurious_q  <= spurious_d;
`endif
        end
    end

    assign inta_n       = inta_n_q;
    assign busy         = busy_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
`ifdef SPURIOUS_DETECT_EN
    assign spurious     = spurious_q;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer with default timing parameters.
// Expected vectors are queued when a sequence is launched and compared when
// vector_valid rises.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_in;
    logic       intr_en;
    logic [7:0] d_in;
    logic       inta_n;
    logic       busy;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ack;
`ifdef SPURIOUS_DETECT_EN
    logic       spurious;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] vec;
        logic       spur;
    } exp_t;

    exp_t sb[$];

    inta_sequencer #(
        .SYNC_STAGES     (2),
        .INTA_LOW_CYCLES (2),
        .INTA_GAP_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .int_in       (int_in),
        .intr_en      (intr_en),
        .d_in         (d_in),
        .inta_n       (inta_n),
        .busy         (busy),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ack   (vector_ack)
`ifdef SPURIOUS_DETECT_EN
        ,
        .spurious     (spurious)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input logic s);
        exp_t e;
        e.vec  = v;
        e.spur = s;
        sb.push_back(e);
    endtask

    task automatic wait_inta(input logic level, input int max_cyc, input string tag);
        int n = 0;
        while (inta_n !== level && n < max_cyc) begin
            step();
            n++;
        end
        if (inta_n !== level) check(tag, 32'(inta_n), 32'(level));
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        int n = 0;
        while (vector_valid !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        if (vector_valid !== 1'b1) check(tag, 32'(vector_valid), 32'd1);
    endtask

    task automatic do_ack();
        vector_ack = 1'b1;
        step();
        check("ack_valid_clr", 32'(vector_valid), 32'd0);
        check("ack_busy_clr", 32'(busy), 32'd0);
        vector_ack = 1'b0;
    endtask

    // Scoreboard compare on each vector_valid rising edge
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (vector_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_vector", 32'(vector), 32'(e.vec));
`ifdef SPURIOUS_DETECT_EN
                    check("sb_spurious", 32'(spurious), 32'(e.spur));
`endif
                end
            end
`ifdef SPURIOUS_DETECT_EN
            else if (spurious) begin
                check("spur_stray", 32'(spurious), 32'd0);
            end
`endif
            prev_valid <= vector_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_inta[9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};

        reset      = 1'b1;
        int_in     = 1'b0;
        intr_en    = 1'b0;
        d_in       = 8'h00;
        vector_ack = 1'b0;
        #2;
        check("rst_inta_n", 32'(inta_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vector", 32'(vector), 32'd0);
        check("rst_valid", 32'(vector_valid), 32'd0);
`ifdef SPURIOUS_DETECT_EN
        check("rst_spurious", 32'(spurious), 32'd0);
`endif
        step();
        step();
        reset = 1'b0;
        step();

        // Basic sequence: two 2-clock pulses, 2-clock gap, vector 7 clocks after int_s
        d_in    = 8'h4A;
        intr_en = 1'b1;
        int_in  = 1'b1;
        push(8'h4A, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("seq_inta_k%0d", k + 1), 32'(inta_n), 32'(exp_inta[k]));
            if (k == 1) check("seq_busy_pre", 32'(busy), 32'd0);
            if (k == 2) check("seq_busy_start", 32'(busy), 32'd1);
            if (k == 7) check("seq_valid_early", 32'(vector_valid), 32'd0);
        end
        check("seq_valid", 32'(vector_valid), 32'd1);
        check("seq_vector", 32'(vector), 32'h4A);

        // HOLD without ack: everything stays put
        d_in = 8'h99;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_vector", 32'(vector), 32'h4A);
            check("hold_valid", 32'(vector_valid), 32'd1);
            check("hold_inta_n", 32'(inta_n), 32'd1);
        end

        // Ack, then back-to-back restart one clock later with int_s still high;
        // PULSE1 data must be ignored and PULSE2 data captured
        do_ack();
        push(8'h21, 1'b0);
        step();
        check("b2b_inta_n", 32'(inta_n), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        d_in = 8'hFF;
        step();
        check("b2b_p1_inta", 32'(inta_n), 32'd0);
        step();
        check("b2b_gap_inta", 32'(inta_n), 32'd1);
        step();
        step();
        check("b2b_p2_inta", 32'(inta_n), 32'd0);
        d_in   = 8'h21;
        int_in = 1'b0;
        step();
        check("b2b_p2b_inta", 32'(inta_n), 32'd0);
        step();
        check("b2b_valid", 32'(vector_valid), 32'd1);
        check("b2b_vector", 32'(vector), 32'h21);
        step();
        do_ack();
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_inta_n", 32'(inta_n), 32'd1);
        end

        // intr_en low blocks a pending INT; raising it starts on the next edge
        intr_en = 1'b0;
        int_in  = 1'b1;
        d_in    = 8'h5C;
        for (int i = 0; i < 20; i++) begin
            step();
            check("masked_inta_n", 32'(inta_n), 32'd1);
            check("masked_busy", 32'(busy), 32'd0);
        end
        intr_en = 1'b1;
        push(8'h5C, 1'b0);
        step();
        check("unmask_inta_n", 32'(inta_n), 32'd0);
        check("unmask_busy", 32'(busy), 32'd1);
        wait_valid(20, "unmask_timeout");
        check("unmask_vector", 32'(vector), 32'h5C);
        int_in = 1'b0;
        step();
        step();
        do_ack();
        step();

`ifdef SPURIOUS_DETECT_EN
        // INT withdrawn during PULSE1: second pulse still issued, spurious flagged
        int_in = 1'b1;
        d_in   = 8'h27;
        push(8'h27, 1'b1);
        wait_inta(1'b0, 20, "spur_p1_timeout");
        int_in = 1'b0;
        wait_inta(1'b1, 20, "spur_gap_timeout");
        wait_inta(1'b0, 20, "spur_p2_timeout");
        check("spur_p2_issued", 32'(inta_n), 32'd0);
        wait_valid(20, "spur_valid_timeout");
        check("spur_vector", 32'(vector), 32'h27);
        check("spur_pulse", 32'(spurious), 32'd1);
        step();
        check("spur_one_clk", 32'(spurious), 32'd0);
        do_ack();
        step();
`endif

        // Reset in the middle of PULSE2 releases INTA_n immediately
        int_in = 1'b1;
        d_in   = 8'h66;
        wait_inta(1'b0, 20, "rst_p1_timeout");
        wait_inta(1'b1, 20, "rst_gap_timeout");
        wait_inta(1'b0, 20, "rst_p2_timeout");
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_inta", 32'(inta_n), 32'd1);
        sb.delete();
        int_in = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_inta", 32'(inta_n), 32'd1);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_valid", 32'(vector_valid), 32'd0);
        end
        check("post_rst_vector", 32'(vector), 32'd0);

        // Fresh sequence after reset proves the FSM restarted from IDLE
        int_in = 1'b1;
        d_in   = 8'hC3;
        push(8'hC3, 1'b0);
        wait_valid(20, "final_timeout");
        check("final_vector", 32'(vector), 32'hC3);
        int_in = 1'b0;
        step();
        do_ack();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-side bus agent downstream of the 8259A-compatible PIC.
- Synchronises the PIC's asynchronous INT output into the CPU clock domain and generates the two 8086-style INTA_n pulses.
- Samples the interrupt vector byte driven on D during the second pulse, then presents it to the CPU core through a valid/ack handshake.
- Owns the D bus read direction only during acknowledge cycles.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the INT synchroniser; legal values are 2 or greater.
- INTA_LOW_CYCLES, 2, clocks each INTA_n pulse is held low; legal values are 1 or greater.
- INTA_GAP_CYCLES, 2, clocks INTA_n is high between the two pulses; legal values are 1 or greater.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- int_in  input  1  PIC INT output; asynchronous.
- intr_en  input  1  CPU interrupt-enable (IF) flag; a new sequence starts only when this is 1.
- d_in  input  8  PIC data bus as seen by the CPU.
- inta_n  output  1  interrupt acknowledge to PIC, active low.
- busy  output  1  high from sequence start until the vector is accepted.
- vector  output  8  captured vector byte.
- vector_valid  output  1  vector holds a valid value.
- vector_ack  input  1  CPU core accepts the vector.
- spurious  output  1  one-cycle pulse; exists only with SPURIOUS_DETECT_EN.

Behaviour:
- Reset values: inta_n=1, busy=0, vector=8'h00, vector_valid=0, spurious=0.
- Reset puts the FSM in IDLE and clears the synchroniser and counters.
- Reset asserted mid-pulse forces inta_n high asynchronously.
- int_s is int_in delayed through SYNC_STAGES flops.
- All FSM decisions use int_s only; int_in is never used directly.
- FSM states: IDLE, PULSE1, GAP, PULSE2, HOLD.
- IDLE: when int_s=1 and intr_en=1, go to PULSE1 and set busy=1 on the same edge.
- PULSE1: inta_n=0 for INTA_LOW_CYCLES clocks, then go to GAP. d_in is ignored in this state.
- GAP: inta_n=1 for INTA_GAP_CYCLES clocks, then go to PULSE2.
- PULSE2: inta_n=0 for INTA_LOW_CYCLES clocks.
  - On the last low cycle, register vector<=d_in and vector_valid<=1 on the edge that leaves PULSE2 for HOLD.
  - inta_n returns high on that same edge.
- HOLD: inta_n=1 and vector is held stable.
  - When vector_ack=1, clear vector_valid and busy on the next edge and go to IDLE.
  - The vector register keeps its last value.
- vector_ack has no effect outside HOLD.
- Once PULSE1 is entered, the sequence always runs to completion. Changes on intr_en or int_in after that do not abort it.
- Back-to-back requests: a new sequence can start at the earliest on the cycle after returning to IDLE. Minimum idle spacing is 1 clock.
- Pulse and gap counters are sized to clog2 of the maximum of the two parameters, plus 1. They reload on every state entry; there is no wrap-around.
- Total latency from the first IDLE cycle with int_s=1 to vector_valid=1 is 2*INTA_LOW_CYCLES + INTA_GAP_CYCLES + 1 clocks. With defaults this is 7.

Optional Feature:
- Macro: SPURIOUS_DETECT_EN.
- With the macro defined:
  - In GAP, int_s is checked on the final gap cycle.
  - If int_s=0 there, PULSE2 is still issued, because the PIC requires the second pulse and returns its IR7 default vector.
  - After capture, spurious pulses high for one clock, coincident with the vector_valid rising edge.
  - The spurious port exists.
- Without the macro: the spurious port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pic_pkg holds:
  - the state enum (IDLE, PULSE1, GAP, PULSE2, HOLD);
  - localparam VEC_W=8;
  - the default timing constants.
- One natural sub-module: sync_ff, a parameterised SYNC_STAGES-deep single-bit synchroniser with async active-high reset. It is reusable for other PIC-facing async inputs.

Test Plan:
- Reset mid-PULSE2 (assert reset while inta_n=0) -> inta_n=1 immediately; busy=0 and vector_valid=0 after release; FSM in IDLE.
- int_in=1, intr_en=1, d_in=8'h4A stable, default params:
  - exactly two inta_n low pulses of 2 clocks each, separated by 2 high clocks;
  - vector=8'h4A with vector_valid=1 seven clocks after int_s rises.
- intr_en=0 with int_in=1 for 20 clocks -> inta_n stays 1 and busy stays 0. Setting intr_en=1 then starts the sequence on the next edge.
- d_in=8'hFF during PULSE1, 8'h21 during PULSE2 -> vector=8'h21 (PULSE1 data ignored).
- vector_ack held 0 for 10 clocks in HOLD -> vector and vector_valid stable, inta_n=1. Then ack=1 -> valid=0 next edge, and a new sequence starts one clock later if int_s is still 1.
- With SPURIOUS_DETECT_EN, int_in dropped during PULSE1, d_in=8'h27 -> PULSE2 still issued, vector=8'h27, spurious pulses for 1 clock together with vector_valid rising.
